// File: rtl/seg_stream_rx.sv
// seg_stream_rx: receiver/decoder for the serial 7-segment display stream
// (DS data, shift clock, STCLK latch strobe, 16-bit 595-style frame).
// Frame = {digit-select one-hot byte, active-low segment byte}, bit 0 first.
// Optional macro SEGRX_STALE_EN: per-digit age counters that drop dvalid
// after STALE_CYCLES clk cycles without a refresh.
// Pipeline: sync -> edge detect -> latch reg -> check reg -> outputs,
// giving SYNC_STAGES+2 clk edges from first stclk sample to frame_stb.

module seg_stream_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int STALE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_in,
  input  logic        ds_in,
  input  logic        stclk_in,
  output logic [31:0] dsq,
  output logic [7:0]  dvalid,
  output logic        frame_stb,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (STALE_CYCLES < 1) begin : g_bad_stale
      $error("STALE_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_LEN  = 2'd1;
  localparam logic [1:0] CODE_POS  = 2'd2;
  localparam logic [1:0] CODE_PAT  = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, ds_sync, st_sync;
  logic                   sclk_prev, st_prev;
  logic                   sclk_s, ds_s, st_s;
  logic                   sclk_rise, st_rise;

  logic [15:0] sr;
  logic [4:0]  bit_cnt;

  logic        lat_vld;
  logic [15:0] lat_sr;
  logic [4:0]  lat_cnt;

  logic [7:0]  sel_byte, seg_byte;
  logic        sel_onehot, seg_ok;
  logic [3:0]  seg_val;
  logic [2:0]  sel_idx;
  logic [1:0]  code_c;

  logic        chk_vld;
  logic [1:0]  chk_code;
  logic [2:0]  chk_idx;
  logic [3:0]  chk_val;

  logic        acc;
  logic [7:0]  acc_mask;
  logic [7:0]  stale_mask;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ds_s      = ds_sync[SYNC_STAGES-1];
  assign st_s      = st_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign st_rise   = st_s & ~st_prev;

  // Input synchronisers and previous-sample registers; idle-high at reset so
  // lines that are high out of reset do not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      ds_sync   <= '1;
      st_sync   <= '1;
      sclk_prev <= 1'b1;
      st_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0], ds_in};
      st_sync   <= {st_sync[SYNC_STAGES-2:0], stclk_in};
      sclk_prev <= sclk_s;
      st_prev   <= st_s;
    end
  end

  // Shift register and saturating bit counter; a latch coinciding with a
  // shift restarts the count at 1 because that shift belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (sclk_rise) sr <= {ds_s, sr[15:1]};
      if (st_rise)
        bit_cnt <= sclk_rise ? 5'd1 : 5'd0;
      else if (sclk_rise && bit_cnt != 5'd31)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Frame register: captures the pre-shift contents on a latch strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vld <= 1'b0;
      lat_sr  <= '0;
      lat_cnt <= '0;
    end else begin
      lat_vld <= st_rise;
      if (st_rise) begin
        lat_sr  <= sr;
        lat_cnt <= bit_cnt;
      end
    end
  end

  // Frame validation and segment decode, in rejection priority order.
  always_comb begin
    sel_byte   = lat_sr[15:8];
    seg_byte   = lat_sr[7:0];
    sel_onehot = (sel_byte != 8'h00) && ((sel_byte & (sel_byte - 8'd1)) == 8'h00);
    sel_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_byte[i]) sel_idx = 3'(7 - i);
    end
    seg_ok  = 1'b1;
    seg_val = 4'h0;
    case (seg_byte)
      8'h03: seg_val = 4'h0;
      8'h9F: seg_val = 4'h1;
      8'h25: seg_val = 4'h2;
      8'h0D: seg_val = 4'h3;
      8'h99: seg_val = 4'h4;
      8'h49: seg_val = 4'h5;
      8'h41: seg_val = 4'h6;
      8'h1F: seg_val = 4'h7;
      8'h01: seg_val = 4'h8;
      8'h09: seg_val = 4'h9;
      8'h11: seg_val = 4'hA;
      8'hC1: seg_val = 4'hB;
      8'h63: seg_val = 4'hC;
      8'h85: seg_val = 4'hD;
      8'h61: seg_val = 4'hE;
      8'h71: seg_val = 4'hF;
      default: seg_ok = 1'b0;
    endcase
    if (lat_cnt != 5'd16)  code_c = CODE_LEN;
    else if (!sel_onehot)  code_c = CODE_POS;
    else if (!seg_ok)      code_c = CODE_PAT;
    else                   code_c = CODE_NONE;
  end

  // Check stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld  <= 1'b0;
      chk_code <= CODE_NONE;
      chk_idx  <= '0;
      chk_val  <= '0;
    end else begin
      chk_vld  <= lat_vld;
      chk_code <= code_c;
      chk_idx  <= sel_idx;
      chk_val  <= seg_val;
    end
  end

  assign acc = chk_vld && (chk_code == CODE_NONE);

  // One-hot mask of the digit being refreshed this cycle.
  always_comb begin
    acc_mask = '0;
    if (acc) acc_mask[chk_idx] = 1'b1;
  end

`ifdef SEGRX_STALE_EN
  localparam int AGE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_CYCLES);

  logic [AGE_W-1:0] age [8];

  // Per-digit age: cleared on refresh, otherwise counts up to AGE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (acc_mask[i])          age[i] <= '0;
        else if (age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // A digit goes stale on the edge where its age reaches AGE_MAX.
  always_comb begin
    stale_mask = '0;
    for (int i = 0; i < 8; i++) stale_mask[i] = (age[i] >= AGE_MAX - 1'b1);
  end
`else
  assign stale_mask = '0;
`endif

  // Output stage: display word, valid bits, strobes, status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsq       <= '0;
      dvalid    <= '0;
      frame_stb <= 1'b0;
      err_stb   <= 1'b0;
      err_code  <= CODE_NONE;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_stb <= acc;
      err_stb   <= chk_vld && (chk_code != CODE_NONE);
      dvalid    <= (dvalid & ~stale_mask) | acc_mask;
      if (acc) begin
        dsq[4*chk_idx +: 4] <= chk_val;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (chk_vld) begin
        err_code <= chk_code;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_stream_rx.sv
// Bench for seg_stream_rx: directed frames driven at clk/4-or-slower edge
// rates; a frame-level model predicts each latch outcome and the clk edge at
// which it must appear, and a compare process checks every output each cycle.
// Build with SEGRX_STALE_EN to also exercise digit ageing (STALE_CYCLES=100).

module tb_seg_stream_rx;

  localparam int SYNC  = 2;
  localparam int STALE = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_in = 1'b0;
  logic        ds_in = 1'b0;
  logic        stclk_in = 1'b0;
  logic [31:0] dsq;
  logic [7:0]  dvalid;
  logic        frame_stb, err_stb;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  seg_stream_rx #(.SYNC_STAGES(SYNC), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .ds_in(ds_in),
    .stclk_in(stclk_in), .dsq(dsq), .dvalid(dvalid), .frame_stb(frame_stb),
    .err_stb(err_stb), .err_code(err_code), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  typedef struct {
    int         edge_n;
    bit         acc;
    int         idx;
    logic [3:0] val;
    logic [1:0] code;
  } ev_t;

  ev_t q[$];

  // Model state.
  logic [15:0] m_sr = '0;
  int          m_cnt = 0;
  logic [31:0] e_dsq = '0;
  logic [7:0]  e_flag = '0;
  int          e_last [8];
  logic [1:0]  e_code = '0;
  logic [15:0] e_fcnt = '0, e_ecnt = '0;
  logic        e_fstb = 1'b0, e_estb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_dvalid();
    logic [7:0] v;
    v = e_flag;
`ifdef SEGRX_STALE_EN
    for (int i = 0; i < 8; i++)
      if (e_flag[i] && (cyc - e_last[i] >= STALE)) v[i] = 1'b0;
`endif
    return v;
  endfunction

  // Compare process: apply model events due at this edge, then check outputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      e_fstb = 1'b0;
      e_estb = 1'b0;
      while (q.size() > 0 && q[0].edge_n <= cyc) begin
        ev_t ev;
        ev = q.pop_front();
        if (ev.acc) begin
          e_dsq[4*ev.idx +: 4] = ev.val;
          e_flag[ev.idx] = 1'b1;
          e_last[ev.idx] = cyc;
          e_fcnt = e_fcnt + 16'd1;
          e_fstb = 1'b1;
        end else begin
          e_code = ev.code;
          if (e_ecnt != 16'hFFFF) e_ecnt = e_ecnt + 16'd1;
          e_estb = 1'b1;
        end
      end
      check("dsq", dsq, e_dsq);
      check("dvalid", {24'd0, dvalid}, {24'd0, exp_dvalid()});
      check("frame_stb", {31'd0, frame_stb}, {31'd0, e_fstb});
      check("err_stb", {31'd0, err_stb}, {31'd0, e_estb});
      check("err_code", {30'd0, err_code}, {30'd0, e_code});
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, e_fcnt});
      check("err_cnt", {16'd0, err_cnt}, {16'd0, e_ecnt});
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Judge the frame as latched now; result is due SYNC+2 edges after the
  // first edge that samples stclk high (the next posedge).
  task automatic model_latch();
    ev_t ev;
    logic [7:0] sel, seg;
    bit hit;
    sel = m_sr[15:8];
    seg = m_sr[7:0];
    hit = 1'b0;
    ev.edge_n = cyc + 1 + SYNC + 2;
    ev.acc = 1'b0;
    ev.idx = 0;
    ev.val = 4'h0;
    ev.code = 2'd0;
    for (int v = 0; v < 16; v++)
      if (seg_tab[v] == seg) begin hit = 1'b1; ev.val = 4'(v); end
    if (m_cnt != 16)             ev.code = 2'd1;
    else if ($countones(sel) != 1) ev.code = 2'd2;
    else if (!hit)               ev.code = 2'd3;
    else begin
      ev.acc = 1'b1;
      for (int p = 0; p < 8; p++) if (sel[p]) ev.idx = 7 - p;
    end
    q.push_back(ev);
    m_cnt = 0;
  endtask

  task automatic model_shift(input logic b);
    m_sr = {b, m_sr[15:1]};
    if (m_cnt < 31) m_cnt++;
  endtask

  task automatic shift_bit(input logic b);
    ds_in = b;
    wait_n(4);
    sclk_in = 1'b1;
    model_shift(b);
    wait_n(4);
    sclk_in = 1'b0;
    wait_n(4);
  endtask

  task automatic latch();
    stclk_in = 1'b1;
    model_latch();
    wait_n(4);
    stclk_in = 1'b0;
    wait_n(4);
  endtask

  task automatic shift_and_latch(input logic b);
    ds_in = b;
    wait_n(4);
    sclk_in = 1'b1;
    stclk_in = 1'b1;
    model_latch();
    model_shift(b);
    wait_n(4);
    sclk_in = 1'b0;
    stclk_in = 1'b0;
    wait_n(4);
  endtask

  task automatic shift_bits(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) shift_bit(f[i % 16]);
  endtask

  task automatic send_frame(input logic [7:0] sel, input logic [7:0] seg);
    shift_bits({sel, seg}, 16);
    latch();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_sr = '0; m_cnt = 0;
    e_dsq = '0; e_flag = '0; e_code = '0; e_fcnt = '0; e_ecnt = '0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(2);
  endtask

  initial begin
    logic [15:0] f2;
    for (int i = 0; i < 8; i++) e_last[i] = 0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(2);
    check("rst_dsq", dsq, 32'h0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);

    // Single frame: digit 0 shows 0.
    send_frame(8'h80, 8'h03);
    wait_n(4);
    check("f1_dvalid", {24'd0, dvalid}, 32'h01);
    check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Full refresh: digit index i shows value i+1.
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h80 >> i, seg_tab[i+1]);
    wait_n(4);
    check("refresh_dsq", dsq, 32'h87654321);
`ifndef SEGRX_STALE_EN
    check("refresh_dvalid", {24'd0, dvalid}, 32'hFF);
`endif
    check("refresh_frame_cnt", {16'd0, frame_cnt}, 32'd8);
    check("refresh_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Length errors: 15 and 17 shifts.
    shift_bits({8'h40, 8'h03}, 15);
    latch();
    check("len15_code", {30'd0, err_code}, 32'd1);
    shift_bits({8'h40, 8'h03}, 17);
    latch();
    check("len17_code", {30'd0, err_code}, 32'd1);
    check("len_err_cnt", {16'd0, err_cnt}, 32'd2);

    // Position and pattern errors.
    send_frame(8'hC0, 8'h03);
    check("pos_code", {30'd0, err_code}, 32'd2);
    send_frame(8'h40, 8'hFF);
    check("pat_code", {30'd0, err_code}, 32'd3);
    check("err_dsq_kept", dsq, 32'h87654321);

    // Back-to-back latches with no shifts: length errors.
    latch();
    latch();
    check("cnt0_code", {30'd0, err_code}, 32'd1);
    check("cnt0_err_cnt", {16'd0, err_cnt}, 32'd6);

    // Simultaneous shift+latch: digit 2 gets A, then digit 7 gets b from
    // the 1 + 15 shifts that follow.
    shift_bits({8'h20, 8'h11}, 16);
    f2 = {8'h01, 8'hC1};
    shift_and_latch(f2[0]);
    for (int i = 1; i < 16; i++) shift_bit(f2[i]);
    latch();
    check("simul_dsq", dsq, 32'hB7654A21);
    check("simul_frame_cnt", {16'd0, frame_cnt}, 32'd10);

    // Reset mid-frame; the next frame is judged on post-reset shifts only.
    shift_bits({8'h02, 8'h09}, 8);
    do_reset();
    check("midrst_dsq", dsq, 32'h0);
    send_frame(8'h10, 8'h61);
    check("midrst_frame_dsq", dsq, 32'h0000E000);
    check("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);

`ifdef SEGRX_STALE_EN
    // Ageing: digit 0 refreshed, then left idle past the threshold.
    do_reset();
    send_frame(8'h80, 8'h9F);
    wait_n(STALE + 20);
    check("stale_dvalid", {24'd0, dvalid}, 32'h00);
    check("stale_dsq_kept", dsq, 32'h00000001);
`endif

    wait_n(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_stream_rx.md
Name: seg_stream_rx

Overview:
- Receiver and decoder for the serial 7-segment display stream: a DS data line, a shift clock and an STCLK latch strobe driving a 595-style 16-bit frame.
- Each frame is {digit-select one-hot byte, active-low segment byte}, with bit 0 shifted first.
- Deserialises frames, validates them, decodes the segment pattern back to a hex nibble, and rebuilds the 8-digit display word plus per-digit valid bits.
- Used as a loopback monitor in the measurement design and as a checker for display-driver output.

Parameters:
SYNC_STAGES, 2, synchroniser flops on each input line (minimum 2)
STALE_CYCLES, 1_000_000, clk cycles without refresh before a digit goes invalid (only with SEGRX_STALE_EN)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
sclk_in  in  1  external shift clock; data is shifted on its rising edge
ds_in  in  1  serial data
stclk_in  in  1  latch strobe; latches on its rising edge
dsq  out  32  decoded digits; digit i at dsq[4i+3:4i]
dvalid  out  8  per-digit valid
frame_stb  out  1  one-cycle pulse per accepted frame
err_stb  out  1  one-cycle pulse per rejected frame
err_code  out  2  reason for the last rejection: 1 length, 2 position, 3 pattern; 0 = none since reset
frame_cnt  out  16  accepted frames, wraps 0xFFFF->0
err_cnt  out  16  rejected frames, saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync release):
  - dsq, dvalid, frame_stb, err_stb, err_code, frame_cnt, err_cnt = 0.
  - Shift register = 0; bit counter = 0.
  - Synchroniser outputs and previous-sample registers reset to 1, so lines idle-high at reset give no edge.
- Edge detect: rise = synced sample 1 while previous sample 0. Each line is evaluated once per clk.
- Shift on sclk rise: sr <= {ds, sr[15:1]}. After 16 shifts, sr[7:0] is the segment byte and sr[15:8] is the digit-select byte.
- Bit counter: +1 per shift, saturates at 31, cleared on every latch.
- Simultaneous sclk and stclk rise in the same cycle (595 semantics):
  - The latch takes sr and the counter value before the shift.
  - The shift then proceeds, and the counter restarts at 1.
- Latch on stclk rise captures {sr, bit counter} into the frame register. Checks are applied next cycle, in priority order:
  1. Count != 16 -> error, code 1.
  2. sr[15:8] not one-hot -> error, code 2.
  3. sr[7:0] not in the segment table -> error, code 3.
  4. Otherwise accept.
- Digit index from select byte: bit 7 -> index 0, bit 6 -> 1, ..., bit 0 -> 7.
- Segment table, value:byte (active-low):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, b:C1, C:63, d:85, E:61, F:71
- Accept:
  - dsq nibble[index] <= decoded value; dvalid[index] <= 1.
  - frame_stb = 1 for one cycle; frame_cnt += 1.
  - err_code unchanged.
- Reject:
  - dsq and dvalid unchanged.
  - err_stb = 1 for one cycle; err_code updated; err_cnt += 1 (saturating).
- Latency: frame_stb/err_stb and the dsq update occur exactly SYNC_STAGES+2 clk edges after the first edge that samples stclk_in high. frame_stb and err_stb are never high together.
- Latch with count 0 (back-to-back stclk with no shifts) is a length error.
- More than 16 shifts before a latch is a length error. The shift register keeps only the last 16 bits.
- Inputs are assumed no faster than clk/4 per edge. Faster edges may be missed; this is not detected.
- Reset mid-frame discards the partial frame; the first post-reset latch is judged on post-reset shifts only.

Optional Feature:
SEGRX_STALE_EN
- Defined:
  - Each digit has an age counter (width clog2(STALE_CYCLES+1)), cleared when that digit is accepted, otherwise +1 per clk, saturating at STALE_CYCLES.
  - When the age reaches STALE_CYCLES, dvalid[i] clears that cycle; the dsq nibble is kept.
  - An accept and the stale threshold in the same cycle: the accept wins and dvalid stays 1.
- Undefined: no age counters; dvalid bits are sticky until reset.

Test Plan:
- Stream frame segbit=0x80, segdata=0x03 (16 shifts, then latch) -> dsq[3:0]=0, dvalid=0x01, frame_stb one pulse at latch+4 clk, frame_cnt=1.
- Full 8-frame refresh for digits 1,2,3,4,5,6,7,8 (indices 0..7) -> dsq=0x87654321, dvalid=0xFF, frame_cnt=8, err_cnt=0.
- Latch after 15 shifts -> err_stb, err_code=1, err_cnt=1, dsq unchanged; same test with 17 shifts -> err_code=1.
- Select byte 0xC0 -> err_code=2; select 0x40 with segment byte 0xFF -> err_code=3; dsq/dvalid unchanged after each.
- sclk and stclk rise in the same cycle after 16 prior shifts -> the frame is accepted from the pre-shift data, and the next latch after 15 more shifts is accepted (count=16).
- With SEGRX_STALE_EN and STALE_CYCLES=100: accept digit 0, then idle -> dvalid[0] clears at exactly 100 cycles after frame_stb; rst_n low mid-frame -> all outputs 0 and counters cleared.
